// File: rtl/fdiv_fsqrt_sequencer.sv
// fdiv_fsqrt_sequencer: stall/iteration sequencer for the iterative FP divide and square-root path.
//
// Accepts an fdiv/fsqrt issue from FP E1, counts down a per-op iteration count while holding
// the integer and FP pipelines stalled, then pulses done for one cycle with the latched destination.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   clrn       asynchronous active-low reset
//   start      fdiv/fsqrt present in E1 and issuing this cycle
//   op         0 = fdiv, 1 = fsqrt (sampled with start)
//   ein        E1 issue enable, start is ignored when low
//   fd_in      destination FP register of the issuing op
//   wf_in      write-enable of the issuing op
//   stall      divide/sqrt stall to the FPU and integer unit
//   busy       iteration in progress
//   count_div  remaining fdiv cycles, 0 when not dividing
//   count_sqrt remaining fsqrt cycles, 0 when not in sqrt
//   done       one-cycle completion pulse
//   wn_ds      latched destination register
//   ww_ds      latched write-enable, qualified by done for writeback
//   op_ds      latched op
module fdiv_fsqrt_sequencer #(
    parameter int DIV_CYCLES  = 14,
    parameter int SQRT_CYCLES = 18,
    parameter int CW          = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          start,
    input  logic          op,
    input  logic          ein,
    input  logic [4:0]    fd_in,
    input  logic          wf_in,
    output logic          stall,
    output logic          busy,
    output logic [CW-1:0] count_div,
    output logic [CW-1:0] count_sqrt,
    output logic          done,
    output logic [4:0]    wn_ds,
    output logic          ww_ds,
    output logic          op_ds
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] SQRT_LOAD = CW'(SQRT_CYCLES - 1);

    if (DIV_CYCLES < 2 || SQRT_CYCLES < 2 ||
        DIV_CYCLES > (1 << CW) - 1 || SQRT_CYCLES > (1 << CW) - 1) begin : g_bad_params
        $error("fdiv_fsqrt_sequencer: cycle counts must be >= 2 and fit in CW bits");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    wn_q, wn_d;
    logic          ww_q, ww_d;
    logic          op_q, op_d;
    logic          acc;

    // Accepting in DONE lets a new op issue on the completion cycle with no bubble.
    assign acc = start & ein & (state_q != BUSY);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wn_d    = wn_q;
        ww_d    = ww_q;
        op_d    = op_q;
        if (acc) begin
            state_d = BUSY;
            count_d = op ? SQRT_LOAD : DIV_LOAD;
            wn_d    = fd_in;
            ww_d    = wf_in;
            op_d    = op;
        end else begin
            case (state_q)
                BUSY: begin
                    if (count_q <= CW'(1)) begin
                        state_d = DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            count_q <= '0;
            wn_q    <= '0;
            ww_q    <= 1'b0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wn_q    <= wn_d;
            ww_q    <= ww_d;
            op_q    <= op_d;
        end
    end

    // Issuing while stalled is an upstream protocol error; the issue is dropped.
    always_ff @(posedge clk) begin
        if (clrn) begin
            assert (!(start && ein && state_q == BUSY))
            else $warning("fdiv_fsqrt_sequencer: start issued while busy, ignored");
        end
    end

    assign busy       = (state_q == BUSY);
    assign stall      = acc | busy;
    assign done       = (state_q == DONE);
    assign count_div  = (busy && !op_q) ? count_q : '0;
    assign count_sqrt = (busy &&  op_q) ? count_q : '0;
    assign wn_ds      = wn_q;
    assign ww_ds      = ww_q;
    assign op_ds      = op_q;
endmodule

// File: tb/tb_fdiv_fsqrt_sequencer.sv
// tb_fdiv_fsqrt_sequencer: self-checking bench for fdiv_fsqrt_sequencer.
module tb_fdiv_fsqrt_sequencer;
    logic       clk = 0, clrn = 0, start = 0, op = 0, ein = 0, wf_in = 0;
    logic [4:0] fd_in = 0;
    logic       stall, busy, done, ww_ds, op_ds;
    logic [4:0] count_div, count_sqrt, wn_ds;
    logic       stall2, busy2, done2, ww_ds2, op_ds2;
    logic [1:0] count_div2, count_sqrt2;
    logic [4:0] wn_ds2;

    fdiv_fsqrt_sequencer dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .ein(ein), .fd_in(fd_in), .wf_in(wf_in),
        .stall(stall), .busy(busy), .count_div(count_div), .count_sqrt(count_sqrt), .done(done),
        .wn_ds(wn_ds), .ww_ds(ww_ds), .op_ds(op_ds)
    );

    fdiv_fsqrt_sequencer #(.DIV_CYCLES(2), .SQRT_CYCLES(3), .CW(2)) dut2 (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .ein(ein), .fd_in(fd_in), .wf_in(wf_in),
        .stall(stall2), .busy(busy2), .count_div(count_div2), .count_sqrt(count_sqrt2), .done(done2),
        .wn_ds(wn_ds2), .ww_ds(ww_ds2), .op_ds(op_ds2)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference: an accepted op occupies cycles a..a+n-1 (stalled) and completes at a+n.
    int         t = 0, a = 0, n = 0;
    bit         has = 0;
    bit [4:0]   m_wn = 0;
    bit         m_ww = 0, m_op = 0;

    typedef struct {
        bit       s, o, e, w;
        bit [4:0] fd;
        bit       stall, done;
        int       cdiv;
        bit [4:0] wn;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, t, act, exp);
        end
    endtask

    function automatic bit m_busy();
        return has && t > a && t < a + n;
    endfunction

    task automatic model_reset();
        has = 0; m_wn = 0; m_ww = 0; m_op = 0;
    endtask

    // Drive one cycle of inputs, check the main DUT against the model at the negedge.
    task automatic cyc(input bit s, input bit o, input bit e, input bit [4:0] fd, input bit w);
        bit bz, dn, acc;
        int cnt;
        start = s; op = o; ein = e; fd_in = fd; wf_in = w;
        @(negedge clk);
        bz  = m_busy();
        dn  = has && t == a + n;
        acc = s && e && !bz && clrn;
        cnt = bz ? a + n - t : 0;
        chk("stall", stall, acc || bz);
        chk("busy", busy, bz);
        chk("done", done, dn);
        chk("count_div", count_div, (bz && !m_op) ? cnt : 0);
        chk("count_sqrt", count_sqrt, (bz && m_op) ? cnt : 0);
        chk("wn_ds", wn_ds, m_wn);
        chk("ww_ds", ww_ds, m_ww);
        chk("op_ds", op_ds, m_op);
        if (acc) begin
            has = 1; a = t; n = o ? 18 : 14; m_wn = fd; m_ww = w; m_op = o;
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            cyc(0, 0, 0, 0, 0);
            nxt();
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            tbl[k].s = (k == 0); tbl[k].o = 0; tbl[k].e = 1; tbl[k].w = 1; tbl[k].fd = 7;
            tbl[k].stall = (k < 14);
            tbl[k].done  = (k == 14);
            tbl[k].cdiv  = (k >= 1 && k <= 13) ? 14 - k : 0;
            tbl[k].wn    = (k == 0) ? 5'd0 : 5'd7;
        end

        // reset state
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_wn", wn_ds, 0);
        idle(2);
        clrn = 1;

        // table-driven fdiv, fd=7
        for (int k = 0; k < 16; k++) begin
            cyc(tbl[k].s, tbl[k].o, tbl[k].e, tbl[k].fd, tbl[k].w);
            chk("tbl_stall", stall, tbl[k].stall);
            chk("tbl_done", done, tbl[k].done);
            chk("tbl_count_div", count_div, tbl[k].cdiv);
            chk("tbl_count_sqrt", count_sqrt, 0);
            chk("tbl_wn", wn_ds, tbl[k].wn);
            if (k == 14) chk("tbl_ww", ww_ds, 1);
            nxt();
        end

        // fsqrt, fd=3
        for (int k = 0; k < 20; k++) begin
            cyc(k == 0, 1, 1, 3, 1);
            if (k == 18) begin
                chk("sqrt_done", done, 1);
                chk("sqrt_wn", wn_ds, 3);
            end
            nxt();
        end

        // back-to-back: fdiv, then fsqrt fd=9 on the DONE cycle
        for (int k = 0; k < 34; k++) begin
            cyc(k == 0 || k == 14, k == 14, 1, (k == 14) ? 5'd9 : 5'd4, 1);
            if (k == 14) begin
                chk("b2b_done", done, 1);
                chk("b2b_stall", stall, 1);
            end
            if (k == 15) chk("b2b_wn", wn_ds, 9);
            if (k == 32) chk("b2b_done2", done, 1);
            nxt();
        end

        // start with ein=0 is ignored
        for (int k = 0; k < 3; k++) begin
            cyc(1, k[0], 0, 5, 1);
            chk("noein_stall", stall, 0);
            nxt();
        end

        // start during BUSY is ignored (protocol warning expected)
        for (int k = 0; k < 16; k++) begin
            cyc(k == 0 || k == 5, 0, 1, (k == 5) ? 5'd20 : 5'd11, 1);
            if (k == 14) begin
                chk("busystart_done", done, 1);
                chk("busystart_wn", wn_ds, 11);
            end
            nxt();
        end

        // reset mid-op at cycle 6
        for (int k = 0; k <= 6; k++) begin
            cyc(k == 0, 0, 1, 13, 1);
            if (k < 6) nxt();
        end
        #2 clrn = 0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cdiv", count_div, 0);
        chk("mid_rst_wn", wn_ds, 0);
        chk("mid_rst_ww", ww_ds, 0);
        model_reset();
        nxt();
        idle(2);
        clrn = 1;
        idle(12);
        for (int k = 0; k < 16; k++) begin
            cyc(k == 0, 0, 1, 17, 0);
            if (k == 14) chk("post_rst_done", done, 1);
            nxt();
        end

        // DIV_CYCLES=2 instance
        for (int k = 0; k < 16; k++) begin
            cyc(k == 0, 0, 1, 2, 1);
            if (k < 4) begin
                chk("p2_stall", stall2, k < 2);
                chk("p2_count_div", count_div2, (k == 1) ? 1 : 0);
                chk("p2_done", done2, k == 2);
            end
            nxt();
        end

        // randomized traffic, never issuing while the model says busy
        for (int k = 0; k < 800; k++) begin
            bit s, e;
            s = $urandom_range(0, 1);
            e = m_busy() ? 1'b0 : ($urandom_range(0, 3) != 0);
            cyc(s, $urandom_range(0, 1), e, 5'($urandom_range(0, 31)), $urandom_range(0, 1));
            nxt();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
